// File: rtl/fft_mag_peak.sv
// Squared-magnitude writer for one FFT frame: streams |X[k]|^2 bytewise
// into BRAM port B and reports the strongest bin of the frame.
module fft_mag_peak #(
    parameter int WIDTH     = 8,
    parameter int DECIMAL   = 4,
    parameter int FFTN      = 8,
    parameter int BASE_ADDR = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            frame_idx,
    input  logic [FFTN*WIDTH-1:0] fr_in,
    input  logic [FFTN*WIDTH-1:0] fi_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_wen,
    output logic [7:0]            peak_bin,
    output logic [2*WIDTH-1:0]    peak_mag
);

    localparam int B  = 2 * WIDTH / 8;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int KW = (FFTN > 1) ? $clog2(FFTN) : 1;
    localparam int MW = 2 * WIDTH;

    localparam logic [BW-1:0] B_LAST = BW'(B - 1);
    localparam logic [KW-1:0] K_LAST = KW'(FFTN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [FFTN*WIDTH-1:0] fr_q, fr_d;
    logic [FFTN*WIDTH-1:0] fi_q, fi_d;
    logic [7:0]            frame_q, frame_d;
    logic [KW-1:0]         k_q, k_d;
    logic [BW-1:0]         b_q, b_d;
    logic [MW-1:0]         mag_q, mag_d;
    logic [MW-1:0]         best_mag_q, best_mag_d;
    logic [KW-1:0]         best_bin_q, best_bin_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           mem_addr_q, mem_addr_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [7:0]            peak_bin_q, peak_bin_d;
    logic [MW-1:0]         peak_mag_q, peak_mag_d;

    logic signed [WIDTH-1:0] re_s, im_s;
    logic signed [MW-1:0]    re_sq, im_sq;
    logic [MW-1:0]           mag_calc;
    logic [BW-1:0]           b_nx;

    // Wraps modulo 2^16 naturally because every term is 16 bits wide.
    function automatic logic [15:0] byte_addr(
        input logic [7:0]    fidx,
        input logic [KW-1:0] k,
        input logic [BW-1:0] b
    );
        return 16'(BASE_ADDR)
             + (16'(fidx) * 16'(FFTN) + 16'(k)) * 16'(B)
             + 16'(b);
    endfunction

    // Each square is non-negative and at most 2^(2W-2), so the sum fits.
    always_comb begin
        re_s     = fr_q[k_q*WIDTH +: WIDTH];
        im_s     = fi_q[k_q*WIDTH +: WIDTH];
        re_sq    = re_s * re_s;
        im_sq    = im_s * im_s;
        mag_calc = $unsigned(re_sq) + $unsigned(im_sq);
        b_nx     = b_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        fr_d       = fr_q;
        fi_d       = fi_q;
        frame_d    = frame_q;
        k_d        = k_q;
        b_d        = b_q;
        mag_d      = mag_q;
        best_mag_d = best_mag_q;
        best_bin_d = best_bin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wen_d  = 1'b0;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    fr_d       = fr_in;
                    fi_d       = fi_in;
                    frame_d    = frame_idx;
                    k_d        = '0;
                    best_mag_d = '0;
                    best_bin_d = '0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                mag_d = mag_calc;
                if (k_q == '0 || mag_calc > best_mag_q) begin
                    best_mag_d = mag_calc;
                    best_bin_d = k_q;
                end
                state_d    = WRITE;
                b_d        = '0;
                mem_wen_d  = 1'b1;
                mem_addr_d = byte_addr(frame_q, k_q, '0);
                mem_din_d  = mag_calc[7:0];
            end
            WRITE: begin
                if (b_q == B_LAST) begin
                    if (k_q == K_LAST) begin
                        state_d    = FIN;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        peak_bin_d = 8'(best_bin_q);
                        peak_mag_d = best_mag_q;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = CALC;
                    end
                end else begin
                    b_d        = b_nx;
                    mem_wen_d  = 1'b1;
                    mem_addr_d = byte_addr(frame_q, k_q, b_nx);
                    mem_din_d  = mag_q[8*b_nx +: 8];
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fr_q       <= '0;
            fi_q       <= '0;
            frame_q    <= '0;
            k_q        <= '0;
            b_q        <= '0;
            mag_q      <= '0;
            best_mag_q <= '0;
            best_bin_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wen_q  <= 1'b0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
        end else begin
            state_q    <= state_d;
            fr_q       <= fr_d;
            fi_q       <= fi_d;
            frame_q    <= frame_d;
            k_q        <= k_d;
            b_q        <= b_d;
            mag_q      <= mag_d;
            best_mag_q <= best_mag_d;
            best_bin_q <= best_bin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wen_q  <= mem_wen_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_wen  = mem_wen_q;
    assign peak_bin = peak_bin_q;
    assign peak_mag = peak_mag_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: hand-computed frames, tie, extreme
// negative input, addressing, back-to-back, ignored start and abort.
module tb_fft_mag_peak;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  frame_idx;
    logic [63:0] fr_in;
    logic [63:0] fi_in;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wen;
    logic [7:0]  peak_bin;
    logic [15:0] peak_mag;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] shadow [0:65535];
    logic [7:0] eb [16];

    fft_mag_peak #(
        .WIDTH(8),
        .DECIMAL(4),
        .FFTN(8),
        .BASE_ADDR(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .frame_idx(frame_idx),
        .fr_in(fr_in),
        .fi_in(fi_in),
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_wen(mem_wen),
        .peak_bin(peak_bin),
        .peak_mag(peak_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_eb();
        for (int i = 0; i < 16; i++) eb[i] = 8'h00;
    endtask

    // Runs one frame from the start edge (edge 0) through cycle 25.
    // restart_cyc: cycle in which a stray start is driven (0 = none).
    // rst_cyc: cycle in which rst_n is driven low (0 = none).
    task automatic run_frame(input logic [7:0]  fidx,
                             input logic [63:0] fr,
                             input logic [63:0] fi,
                             input logic [7:0]  exp_pb,
                             input logic [15:0] exp_pm,
                             input int          restart_cyc,
                             input int          rst_cyc);
        logic [15:0] base;
        logic        aborted, e_busy, e_done, e_wen;
        base = 16'(100 + 16 * int'(fidx));
        for (int i = 0; i < 16; i++) shadow[base + 16'(i)] = 8'hEE;
        @(negedge clk);
        frame_idx = fidx;
        fr_in = fr;
        fi_in = fi;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            aborted = (rst_cyc != 0) && (n > rst_cyc);
            e_busy  = !aborted && (n < 25);
            e_done  = !aborted && (n == 25);
            e_wen   = !aborted && (n <= 24) && ((n - 1) % 3 != 0);
            check($sformatf("busy c%0d", n), 32'(busy), 32'(e_busy));
            check($sformatf("done c%0d", n), 32'(done), 32'(e_done));
            check($sformatf("wen c%0d", n), 32'(mem_wen), 32'(e_wen));
            if (e_wen && mem_wen === 1'b1) begin
                check($sformatf("addr c%0d", n), 32'(mem_addr),
                      32'(base + 16'(((n - 1) / 3) * 2 + ((n - 1) % 3) - 1)));
                shadow[mem_addr] = mem_din;
            end
            if (aborted) begin
                check($sformatf("abort pbin c%0d", n), 32'(peak_bin), 0);
                check($sformatf("abort pmag c%0d", n), 32'(peak_mag), 0);
            end
            if (n == 25 && rst_cyc == 0) begin
                check("peak_bin", 32'(peak_bin), 32'(exp_pb));
                check("peak_mag", 32'(peak_mag), 32'(exp_pm));
                for (int i = 0; i < 16; i++)
                    check($sformatf("byte %0d", int'(base) + i),
                          32'(shadow[base + 16'(i)]), 32'(eb[i]));
            end
            // Inputs wiggle after capture to prove they were latched.
            start = (n == restart_cyc);
            rst_n = (n != rst_cyc);
            fr_in = 64'hA5A5_A5A5_A5A5_A5A5;
            fi_in = 64'h5A5A_5A5A_5A5A_5A5A;
            frame_idx = 8'hFF;
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        frame_idx = '0;
        fr_in = '0;
        fi_in = '0;

        // Reset held with start asserted and busy inputs
        @(negedge clk);
        start = 1'b1;
        frame_idx = 8'h07;
        fr_in = 64'h1234_5678_9ABC_DEF0;
        fi_in = 64'h0FED_CBA9_8765_4321;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst busy", 32'(busy), 0);
            check("rst done", 32'(done), 0);
            check("rst wen", 32'(mem_wen), 0);
            check("rst addr", 32'(mem_addr), 0);
            check("rst din", 32'(mem_din), 0);
            check("rst pbin", 32'(peak_bin), 0);
            check("rst pmag", 32'(peak_mag), 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle busy", 32'(busy), 0);
        check("idle wen", 32'(mem_wen), 0);

        // Single tone: bin2 re=0x10 -> mag 0x0100
        clear_eb();
        eb[5] = 8'h01;
        run_frame(8'd0, 64'h0000_0000_0010_0000, 64'h0, 8'd2, 16'h0100, 0, 0);

        // Extreme negative: bin5 re=im=-128 -> 0x8000
        clear_eb();
        eb[11] = 8'h80;
        run_frame(8'd0, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                  8'd5, 16'h8000, 0, 0);

        // Tie: bins 1 and 6 are 3-4j -> 25, lower index wins
        clear_eb();
        eb[2] = 8'h19;
        eb[12] = 8'h19;
        run_frame(8'd0, 64'h0003_0000_0000_0300, 64'h00FC_0000_0000_FC00,
                  8'd1, 16'd25, 0, 0);

        // Frame 3 (addr 148..163), then frame 4 back to back (164..179)
        clear_eb();
        eb[0] = 8'h04;
        eb[14] = 8'h05;
        run_frame(8'd3, 64'h0100_0000_0000_0002, 64'h0200_0000_0000_0000,
                  8'd7, 16'd5, 0, 0);
        clear_eb();
        eb[6] = 8'h02;
        eb[8] = 8'h01;
        eb[9] = 8'h3F;
        run_frame(8'd4, 64'h0000_007F_FF00_0000, 64'h0000_0000_FF00_0000,
                  8'd4, 16'h3F01, 0, 0);
        check("frame3 first", 32'(shadow[16'd148]), 32'h04);
        check("frame4 last", 32'(shadow[16'd179]), 32'h00);

        // Stray start at cycle 5 is ignored
        clear_eb();
        eb[5] = 8'h01;
        run_frame(8'd0, 64'h0000_0000_0010_0000, 64'h0, 8'd2, 16'h0100, 5, 0);

        // Reset at cycle 10 aborts the frame
        run_frame(8'd0, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                  8'd5, 16'h8000, 0, 10);

        // A fresh frame after the abort runs to completion
        clear_eb();
        eb[2] = 8'h19;
        eb[12] = 8'h19;
        run_frame(8'd0, 64'h0003_0000_0000_0300, 64'h00FC_0000_0000_FC00,
                  8'd1, 16'd25, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
